// File: rtl/uart_pkg.sv
// Shared byte-width constant, default FIFO depth and byte type for the UART receive path.
package uart_pkg;
  localparam int UART_BYTE_W        = 8;
  localparam int UART_DEPTH_DEFAULT = 16;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: synchronous write, asynchronous read, array never reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [UART_BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [UART_BYTE_W-1:0] rdata
);

  uart_byte_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO between a UART controller and a byte consumer, with sticky overrun.
// Optional macro UART_RX_FIFO_DROP_CNT_EN adds a saturating 8-bit dropped-byte counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = UART_DEPTH_DEFAULT,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wb_flag,
  input  logic [UART_BYTE_W-1:0]   wb_data,
  output logic                     ready_to_receive,
  input  logic                     rd_en,
  output logic [UART_BYTE_W-1:0]   rd_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     flush,
  output logic                     overrun,
  input  logic                     clr_overrun
`ifdef UART_RX_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]               drop_count
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop_req;
  logic              push;
  logic              pop;
  logic              drop;
  uart_byte_t        head;

  assign empty            = (count == '0);
  assign full             = (count == CNT_W'(DEPTH));
  assign almost_full      = (count >= CNT_W'(AFULL_LEVEL));
  assign ready_to_receive = ~full;

  // A pop frees a slot in the same edge, so a full FIFO still accepts a byte alongside it.
  assign pop_req = rd_en & ~empty;
  assign push    = wb_flag & (~full | pop_req) & ~flush;
  assign pop     = pop_req & ~flush;
  assign drop    = wb_flag & full & ~pop_req;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wb_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign rd_data = empty ? '0 : head;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Set wins over clear so a byte lost in the clearing cycle is never hidden.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          drop_count <= 8'h00;
    else if (clr_overrun)                  drop_count <= drop ? 8'h01 : 8'h00;
    else if (drop && drop_count != 8'hFF)  drop_count <= drop_count + 8'h01;
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized checks of uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFULL = DEPTH - 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       wb_flag, rd_en, flush, clr_overrun;
  logic [7:0] wb_data;
  logic       ready_to_receive, empty, full, almost_full, overrun;
  logic [7:0] rd_data;
  logic [4:0] count;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  bit         m_ovr;
  int         m_dc;

  always #5 clock = ~clock;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .wb_flag          (wb_flag),
    .wb_data          (wb_data),
    .ready_to_receive (ready_to_receive),
    .rd_en            (rd_en),
    .rd_data          (rd_data),
    .empty            (empty),
    .full             (full),
    .almost_full      (almost_full),
    .count            (count),
    .flush            (flush),
    .overrun          (overrun),
    .clr_overrun      (clr_overrun)
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    .drop_count       (drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".afull"}, 32'(almost_full), 32'(n >= AFULL));
    chk({tag, ".ready"}, 32'(ready_to_receive), 32'(n != DEPTH));
    chk({tag, ".rd_data"}, 32'(rd_data), (n > 0) ? 32'(q[0]) : 32'h0);
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
`ifdef UART_RX_FIFO_DROP_CNT_EN
    chk({tag, ".drop_count"}, 32'(drop_count), 32'(m_dc));
`endif
  endtask

  // One clock: apply inputs, advance the model by the FIFO rules, then compare after the edge.
  task automatic cyc(input string tag, input logic f, input logic [7:0] d, input logic r,
                     input logic fl, input logic co);
    bit do_pop, do_push, do_drop;
    wb_flag = f; wb_data = d; rd_en = r; flush = fl; clr_overrun = co;
    do_pop  = r && (q.size() > 0);
    do_push = f && ((q.size() < DEPTH) || do_pop);
    do_drop = f && (q.size() == DEPTH) && !do_pop;
    @(posedge clock);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    if (do_drop) m_ovr = 1'b1;
    else if (co) m_ovr = 1'b0;
    if (co) m_dc = do_drop ? 1 : 0;
    else if (do_drop && m_dc < 255) m_dc++;
    #1;
    wb_flag = 0; rd_en = 0; flush = 0; clr_overrun = 0;
    check_all(tag);
  endtask

  task automatic do_reset();
    #3;
    reset_n = 1'b0;
    q.delete(); m_ovr = 0; m_dc = 0;
    #1;
    check_all("reset_async");
    @(posedge clock); #1;
    check_all("reset_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    wb_flag = 0; wb_data = 0; rd_en = 0; flush = 0; clr_overrun = 0;
    reset_n = 1'b1;
    q.delete(); m_ovr = 0; m_dc = 0;
    @(posedge clock); #1;
    do_reset();

    cyc("push_a5", 1, 8'hA5, 0, 0, 0);
    cyc("pop_a5", 0, 0, 1, 0, 0);
    cyc("pop_empty", 0, 0, 1, 0, 0);
    cyc("push_pop_empty", 1, 8'h11, 1, 0, 0);
    cyc("drain1", 0, 0, 1, 0, 0);

    for (int i = 0; i < DEPTH; i++) cyc("fill", 1, 8'(i), 0, 0, 0);
    cyc("overflow_ff", 1, 8'hFF, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc("drain", 0, 0, 1, 0, 0);
    cyc("clr_ovr", 0, 0, 0, 0, 1);

    for (int i = 0; i < DEPTH; i++) cyc("fill2", 1, 8'(i), 0, 0, 0);
    cyc("full_push_pop", 1, 8'h55, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc("drain2", 0, 0, 1, 0, 0);

    cyc("wrap_seed", 1, 8'h80, 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc("wrap", 1, 8'(8'h81 + i), 1, 0, 0);
    cyc("wrap_drain", 0, 0, 1, 0, 0);

    for (int i = 0; i < 5; i++) cyc("hold5", 1, 8'(8'hC0 + i), 0, 0, 0);
    do_reset();
    cyc("push_3c", 1, 8'h3C, 0, 0, 0);
    cyc("pop_3c", 0, 0, 1, 0, 0);

    for (int i = 0; i < 6; i++) cyc("pre_flush", 1, 8'(8'h60 + i), 0, 0, 0);
    cyc("flush_prio", 1, 8'h77, 1, 1, 0);
    cyc("post_flush", 1, 8'h78, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) cyc("fill3", 1, 8'(i), 0, 0, 0);
    cyc("set_vs_clr", 1, 8'hEE, 0, 0, 1);
    cyc("flush_keeps_ovr", 0, 0, 0, 1, 0);
    cyc("clr_ovr2", 0, 0, 0, 0, 1);

`ifdef UART_RX_FIFO_DROP_CNT_EN
    for (int i = 0; i < DEPTH; i++) cyc("fill_dc", 1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 300; i++) cyc("drop_sat", 1, 8'(i), 0, 0, 0);
    cyc("dc_clr", 0, 0, 0, 0, 1);
    cyc("dc_flush", 0, 0, 0, 1, 0);
`endif

    // Alternating push-heavy and pop-heavy phases so full, empty and overrun all recur.
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 60; i++) begin
        logic f, r, fl, co;
        f  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 80 : 25));
        r  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 25 : 80));
        fl = ($urandom_range(0, 99) < 2);
        co = ($urandom_range(0, 99) < 5);
        cyc("rand", f, 8'($urandom), r, fl, co);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
